// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional retired-instruction counter is enabled with IFU_FETCH_COUNT_EN.
package ifu_pkg;

  localparam int IFU_DATA_W = 8;
  localparam int IFU_IR_W   = 2 * IFU_DATA_W;

  localparam logic MEM_CS_ACTIVE = 1'b0;
  localparam logic MEM_CS_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH_LO = 2'd1,
    ST_FETCH_HI = 2'd2,
    ST_HOLD     = 2'd3
  } ifu_state_e;

  function automatic logic is_fetch_state(input ifu_state_e s);
    return (s == ST_FETCH_LO) || (s == ST_FETCH_HI);
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: async reset, load has priority over increment.
module ifu_pc_reg #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc_q_o,
  output logic [ADDR_W-1:0] pc_d_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: redirect beats sequential advance; wraps modulo 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (inc) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_q_o = pc_q;
  assign pc_d_o = pc_d;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Two-byte instruction fetch with valid/ready output and redirect support.
// Define IFU_FETCH_COUNT_EN to build the saturating retired-instruction counter.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}}
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                enable,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_value,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_cs,
  output logic                mem_wr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [2*DATA_W-1:0] ir_out,
  output logic                ir_valid,
  input  logic                ir_ready,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                fetch_busy,
  output logic [15:0]         fetch_count
);

  localparam int IR_W = 2 * DATA_W;

  ifu_state_e        state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_cs_q, mem_cs_d;
  logic              fetch_busy_q, fetch_busy_d;
  logic              pc_inc;
  logic              handshake;
  logic [ADDR_W-1:0] pc_q, pc_d;

  assign handshake = ir_valid_q & ir_ready;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET)
  ) u_pc_reg (
    .clk        (CLK),
    .rst        (Reset),
    .load       (pc_load),
    .load_value (pc_load_value),
    .inc        (pc_inc),
    .pc_q_o     (pc_q),
    .pc_d_o     (pc_d)
  );

  // Next-state and datapath; memory-side outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_inc     = 1'b0;
    if (pc_load) begin
      ir_valid_d = 1'b0;
      state_d    = enable ? ST_FETCH_LO : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = ST_FETCH_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH_LO: begin
          ir_d[DATA_W-1:0] = mem_data;
          pc_inc           = 1'b1;
          state_d          = ST_FETCH_HI;
        end
        ST_FETCH_HI: begin
          ir_d[IR_W-1:DATA_W] = mem_data;
          pc_inc              = 1'b1;
          ir_valid_d          = 1'b1;
          state_d             = ST_HOLD;
        end
        ST_HOLD: begin
          if (handshake) begin
            ir_valid_d = 1'b0;
            state_d    = enable ? ST_FETCH_LO : ST_IDLE;
          end else begin
            state_d    = ST_HOLD;
          end
        end
        default: begin
          ir_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      endcase
    end
    // enable is sampled only when leaving IDLE/HOLD, so a started fetch always completes
    fetch_busy_d = is_fetch_state(state_d);
    mem_cs_d     = fetch_busy_d ? MEM_CS_ACTIVE : MEM_CS_IDLE;
    mem_addr_d   = fetch_busy_d ? pc_d : {ADDR_W{1'b0}};
  end

  // FSM and output registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      ir_q         <= {IR_W{1'b0}};
      ir_valid_q   <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_cs_q     <= MEM_CS_IDLE;
      fetch_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_cs_q     <= mem_cs_d;
      fetch_busy_q <= fetch_busy_d;
    end
  end

`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  // Saturating count of consumed instructions.
  always_comb begin
    if (handshake && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_count_q <= 16'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 16'h0000;
`endif

  assign mem_addr   = mem_addr_q;
  assign mem_cs     = mem_cs_q;
  assign mem_wr     = 1'b0;
  assign ir_out     = ir_q;
  assign ir_valid   = ir_valid_q;
  assign pc_out     = pc_q;
  assign fetch_busy = fetch_busy_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios plus random traffic.
module tb_instruction_fetch_unit;

`ifdef IFU_FETCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        CLK;
  logic        Reset;
  logic        enable;
  logic        pc_load;
  logic [7:0]  pc_load_value;
  logic [7:0]  mem_addr;
  logic        mem_cs;
  logic        mem_wr;
  logic [7:0]  mem_data;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  pc_out;
  logic        fetch_busy;
  logic [15:0] fetch_count;

  logic [7:0] mem [256];
  assign mem_data = mem[mem_addr];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] word;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] next_addr = 8'h00;
  int         hs_cnt    = 0;

  instruction_fetch_unit dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .enable        (enable),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .mem_addr      (mem_addr),
    .mem_cs        (mem_cs),
    .mem_wr        (mem_wr),
    .mem_data      (mem_data),
    .ir_out        (ir_out),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .pc_out        (pc_out),
    .fetch_busy    (fetch_busy),
    .fetch_count   (fetch_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!ir_valid && n < max_cycles);
    chk({name, "_timeout"}, {31'd0, ir_valid}, 32'd1);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"},    {24'd0, pc_out},      32'h00);
    chk({tag, "_ir"},    {16'd0, ir_out},      32'h0000);
    chk({tag, "_valid"}, {31'd0, ir_valid},    32'd0);
    chk({tag, "_cs"},    {31'd0, mem_cs},      32'd1);
    chk({tag, "_addr"},  {24'd0, mem_addr},    32'h00);
    chk({tag, "_busy"},  {31'd0, fetch_busy},  32'd0);
    chk({tag, "_count"}, {16'd0, fetch_count}, 32'd0);
  endtask

  // Monitor: inputs are driven just after the rising edge, so at the falling edge
  // they are exactly what the next rising edge will act on.
  always @(negedge CLK) begin
    exp_t       e;
    logic [7:0] a1;
    logic [7:0] a2;
    if (Reset) begin
      sb_q.delete();
      next_addr = 8'h00;
      hs_cnt    = 0;
    end else begin
      chk("mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("fetch_count", {16'd0, fetch_count}, CNT_EN ? hs_cnt : 32'd0);
      if (ir_valid && ir_ready) begin
        if (sb_q.size() == 0) begin
          a1      = next_addr + 8'd1;
          e.addr  = next_addr;
          e.word  = {mem[a1], mem[next_addr]};
          sb_q.push_back(e);
          next_addr = next_addr + 8'd2;
        end
        e  = sb_q.pop_front();
        a2 = e.addr + 8'd2;
        chk("sb_ir_out", {16'd0, ir_out}, {16'd0, e.word});
        chk("sb_pc_out", {24'd0, pc_out}, {24'd0, a2});
        if (hs_cnt < 65535) hs_cnt++;
      end
      if (pc_load) begin
        sb_q.delete();
        next_addr = pc_load_value;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[8'h00] = 8'hE4;
    mem[8'h01] = 8'h44;
    mem[8'h02] = 8'hA8;
    mem[8'h03] = 8'hF4;
    mem[8'hFF] = 8'h5A;

    Reset         = 1'b1;
    enable        = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = 8'h00;
    ir_ready      = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");

    // First instruction: valid on the third edge after enable.
    Reset  = 1'b0;
    enable = 1'b1;
    step();
    step();
    chk("lat_not_yet", {31'd0, ir_valid}, 32'd0);
    step();
    chk("lat_valid", {31'd0, ir_valid}, 32'd1);
    chk("first_ir",  {16'd0, ir_out},   32'h44E4);
    chk("first_pc",  {24'd0, pc_out},   32'h02);

    // Held output while decode stalls.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {31'd0, ir_valid}, 32'd1);
      chk("hold_ir",    {16'd0, ir_out},   32'h44E4);
      chk("hold_cs",    {31'd0, mem_cs},   32'd1);
      chk("hold_pc",    {24'd0, pc_out},   32'h02);
    end
    ir_ready = 1'b1;
    step();
    chk("after_hs_valid", {31'd0, ir_valid}, 32'd0);
    wait_valid("second", 10);
    chk("second_ir", {16'd0, ir_out}, 32'hF4A8);
    chk("second_pc", {24'd0, pc_out}, 32'h04);

    // Asynchronous reset in the middle of FETCH_HI.
    pulse_reset();
    step();
    step();
    chk("mid_hi_busy", {31'd0, fetch_busy}, 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk_reset_outputs("async_rst");

    // Redirect to 0xFF during FETCH_HI: in-flight instruction dropped, wrap fetch.
    step();
    Reset = 1'b0;
    step();
    step();
    pc_load       = 1'b1;
    pc_load_value = 8'hFF;
    step();
    pc_load = 1'b0;
    chk("redir_valid", {31'd0, ir_valid}, 32'd0);
    chk("redir_pc",    {24'd0, pc_out},   32'hFF);
    wait_valid("wrap", 10);
    chk("wrap_ir", {16'd0, ir_out}, 32'hE45A);
    chk("wrap_pc", {24'd0, pc_out}, 32'h01);

    // enable dropped during FETCH_LO: finish, hand off, then idle.
    pulse_reset();
    step();
    enable = 1'b0;
    step();
    step();
    chk("drop_valid", {31'd0, ir_valid}, 32'd1);
    chk("drop_ir",    {16'd0, ir_out},   32'h44E4);
    step();
    step();
    chk("drop_cs",    {31'd0, mem_cs},     32'd1);
    chk("drop_busy",  {31'd0, fetch_busy}, 32'd0);
    chk("drop_pc",    {24'd0, pc_out},     32'h02);
    chk("drop_valid0",{31'd0, ir_valid},   32'd0);

    // Four back-to-back instructions.
    pulse_reset();
    enable = 1'b1;
    for (int i = 0; i < 13; i++) step();
    chk("count4", {16'd0, fetch_count}, CNT_EN ? 32'd4 : 32'd0);

    // Random traffic checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom_range(0, 7) != 0);
      ir_ready      = ($urandom_range(0, 2) != 0);
      pc_load       = ($urandom_range(0, 15) == 0);
      pc_load_value = 8'($urandom_range(0, 255));
      step();
    end
    pc_load = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
